// File: rtl/wb_uart_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the dual-UART slave port.
// Define WB_ARB_TIMEOUT_EN to enable the stalled-slave watchdog.
module wb_uart_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  output logic [1:0]      gnt_o,
  output logic            timeout_o
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [DW-1:0] WD_DATA = DW'(32'hDEADBEEF);

  if (TIMEOUT < 2) begin : g_timeout_check
    $error("wb_uart_arbiter: TIMEOUT must be >= 2");
  end

  state_t          r_state;
  logic            r_last;
  logic [1:0]      r_gnt;
  logic            r_timeout;

  logic            w_req0;
  logic            w_req1;
  logic            w_own0;
  logic            w_own1;
  logic            w_o_cyc;
  logic            w_o_stb;
  logic            w_o_we;
  logic [DW/8-1:0] w_o_sel;
  logic [AW-1:0]   w_o_adr;
  logic [DW-1:0]   w_o_dat;
  logic            w_own_stall;
  logic            w_wd_fire;
  logic            w_ack;
  logic [DW-1:0]   w_rdat;

  assign w_req0 = m0_cyc_i & m0_stb_i;
  assign w_req1 = m1_cyc_i & m1_stb_i;
  assign w_own0 = (r_state == OWN0);
  assign w_own1 = (r_state == OWN1);

  always_comb begin
    w_o_cyc = 1'b0;
    w_o_stb = 1'b0;
    w_o_we  = 1'b0;
    w_o_sel = '0;
    w_o_adr = '0;
    w_o_dat = '0;
    if (w_own0) begin
      w_o_cyc = m0_cyc_i;
      w_o_stb = m0_stb_i;
      w_o_we  = m0_we_i;
      w_o_sel = m0_sel_i;
      w_o_adr = m0_adr_i;
      w_o_dat = m0_dat_i;
    end else if (w_own1) begin
      w_o_cyc = m1_cyc_i;
      w_o_stb = m1_stb_i;
      w_o_we  = m1_we_i;
      w_o_sel = m1_sel_i;
      w_o_adr = m1_adr_i;
      w_o_dat = m1_dat_i;
    end
  end

  assign w_own_stall = w_o_cyc & w_o_stb & ~s_ack_i;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  assign w_wd_fire = w_own_stall & (r_cnt == CW'(TIMEOUT - 1));
`else
  assign w_wd_fire = 1'b0;
`endif

  // An ack is only forwarded while the owner still holds cyc; late acks vanish.
  assign w_ack  = (w_o_cyc & s_ack_i) | w_wd_fire;
  assign w_rdat = w_wd_fire ? WD_DATA : s_dat_i;

  assign s_cyc_o = w_o_cyc;
  assign s_stb_o = w_o_stb & ~w_wd_fire;
  assign s_we_o  = w_o_we;
  assign s_sel_o = w_o_sel;
  assign s_adr_o = w_o_adr;
  assign s_dat_o = w_o_dat;

  assign m0_ack_o = w_own0 & w_ack;
  assign m1_ack_o = w_own1 & w_ack;
  assign m0_dat_o = w_own0 ? w_rdat : '0;
  assign m1_dat_o = w_own1 ? w_rdat : '0;

  assign gnt_o     = r_gnt;
  assign timeout_o = r_timeout;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state   <= IDLE;
      r_last    <= 1'b1;
      r_gnt     <= 2'b00;
      r_timeout <= 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
      r_cnt     <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          // On a tie, the master that did not own the bus last wins.
          if (w_req0 && (!w_req1 || r_last)) begin
            r_state <= OWN0;
            r_gnt   <= 2'b01;
          end else if (w_req1) begin
            r_state <= OWN1;
            r_gnt   <= 2'b10;
          end
        end
        OWN0: begin
          if (!m0_cyc_i) begin
            r_state <= IDLE;
            r_gnt   <= 2'b00;
            r_last  <= 1'b0;
          end
        end
        OWN1: begin
          if (!m1_cyc_i) begin
            r_state <= IDLE;
            r_gnt   <= 2'b00;
            r_last  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= 2'b00;
        end
      endcase
      if (w_wd_fire) r_timeout <= 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
      if (w_own_stall && !w_wd_fire) r_cnt <= r_cnt + CW'(1);
      else                           r_cnt <= '0;
`endif
    end
  end

endmodule
